// File: rtl/poly_eval_if.sv
// poly_eval_if: bus between a controller and the poly_eval Horner evaluator.
//   master: drives coef_we/coef_addr/coef_data (coefficient writes),
//           x_in (argument) and start; observes busy, done, result, zero, overflow.
//   slave : the evaluator side of the same signals.
interface poly_eval_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned XW    = 8,
    parameter int unsigned CAW   = 2
);
    logic             coef_we;
    logic [CAW-1:0]   coef_addr;
    logic [WIDTH-1:0] coef_data;
    logic [XW-1:0]    x_in;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output coef_we, coef_addr, coef_data, x_in, start,
        input  busy, done, result, zero, overflow
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, x_in, start,
        output busy, done, result, zero, overflow
    );
endinterface

// File: rtl/poly_eval.sv
// poly_eval: evaluates S = c[DEGREE]*X^DEGREE + ... + c[0] by Horner's method on
// one shared multiply/add datapath (registers X, S, H) under a small FSM.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset (clears coefficients too)
//   bus  - poly_eval_if.slave: coefficient write port, x_in/start request,
//          busy/done handshake, result (S register), zero (combinational),
//          sticky overflow for the current/last evaluation
// Optional build macro POLY_EVAL_SAT_EN: overflowing MUL/ADD saturate to all-ones
// instead of wrapping modulo 2^WIDTH.
module poly_eval #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned XW     = 8,
    parameter int unsigned DEGREE = 2,
    parameter int unsigned CAW    = (DEGREE == 0) ? 1 : $clog2(DEGREE + 1)
) (
    input  logic       clk,
    input  logic       rst,
    poly_eval_if.slave bus
);
    localparam int unsigned   NCOEF    = DEGREE + 1;
    localparam int unsigned   PW       = 2 * WIDTH;
    localparam int            NDEG     = int'(DEGREE);
    localparam logic [CAW-1:0] IDX_INIT = CAW'((DEGREE == 0) ? 0 : DEGREE - 1);
    localparam logic [CAW:0]  ADDR_MAX = (CAW + 1)'(DEGREE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [CAW-1:0]   idx_q, idx_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] coef_q [NCOEF];

    logic [XW-1:0]    x_in_w;
    logic [WIDTH-1:0] c_idx;
    logic [PW-1:0]    prod;
    logic [WIDTH:0]   sum;
    logic             mul_ov, add_ov;
    logic [WIDTH-1:0] mul_val, add_val;
    logic             coef_wr_ok;

    assign x_in_w = bus.x_in;

    // Coefficient selected by the Horner index (only c[0..DEGREE-1] are ever added).
    always_comb begin
        c_idx = '0;
        for (int i = 0; i < NDEG; i++) begin
            if (idx_q == CAW'(i)) c_idx = coef_q[i];
        end
    end

    // Shared datapath with overflow detection.
    assign prod   = PW'(s_q) * PW'(x_q);
    assign mul_ov = |prod[PW-1:WIDTH];
    assign sum    = (WIDTH + 1)'(h_q) + (WIDTH + 1)'(c_idx);
    assign add_ov = sum[WIDTH];

`ifdef POLY_EVAL_SAT_EN
    assign mul_val = mul_ov ? '1 : prod[WIDTH-1:0];
    assign add_val = add_ov ? '1 : sum[WIDTH-1:0];
`else
    assign mul_val = prod[WIDTH-1:0];
    assign add_val = sum[WIDTH-1:0];
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        x_d     = x_q;
        h_d     = h_q;
        idx_d   = idx_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = WIDTH'(x_in_w);
                    s_d     = coef_q[DEGREE];
                    idx_d   = IDX_INIT;
                    ov_d    = 1'b0;
                    state_d = (DEGREE == 0) ? DONE : MUL;
                end
            end
            MUL: begin
                h_d     = mul_val;
                ov_d    = ov_q | mul_ov;
                state_d = ADD;
            end
            ADD: begin
                s_d  = add_val;
                ov_d = ov_q | add_ov;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - CAW'(1);
                    state_d = MUL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            x_q     <= '0;
            h_q     <= '0;
            idx_q   <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            x_q     <= x_d;
            h_q     <= h_d;
            idx_q   <= idx_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Coefficient file: writable only while idle; out-of-range addresses dropped.
    assign coef_wr_ok = (state_q == IDLE) && bus.coef_we && ({1'b0, bus.coef_addr} <= ADDR_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NCOEF); i++) coef_q[i] <= '0;
        end else if (coef_wr_ok) begin
            for (int i = 0; i < int'(NCOEF); i++) begin
                if (bus.coef_addr == CAW'(i)) coef_q[i] <= bus.coef_data;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = s_q;
    assign bus.overflow = ov_q;
    assign bus.zero     = (s_q == '0);
endmodule

// File: tb/tb_poly_eval.sv
// tb_poly_eval: randomized self-checking bench for poly_eval (DEGREE=2 and DEGREE=0
// instances) against a plain-arithmetic Horner reference model.
module tb_poly_eval;
    localparam int unsigned W    = 16;
    localparam int unsigned XW   = 8;
    localparam int unsigned D    = 2;
    localparam longint unsigned MAXV = 64'd65535;
`ifdef POLY_EVAL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;

    poly_eval_if #(.WIDTH(W), .XW(XW), .CAW(2)) bus ();
    poly_eval_if #(.WIDTH(W), .XW(XW), .CAW(1)) bus0 ();

    poly_eval #(.WIDTH(W), .XW(XW), .DEGREE(D)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    poly_eval #(.WIDTH(W), .XW(XW), .DEGREE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int vectors    = 0;
    int miscompares = 0;
    int unsigned m_c [D+1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: Horner evaluation with explicit overflow rules.
    function automatic void model(input int unsigned x, output int unsigned res, output bit ov);
        longint unsigned s, p;
        s  = longint'(m_c[D]);
        ov = 1'b0;
        for (int i = int'(D) - 1; i >= 0; i--) begin
            p = s * longint'(x);
            if (p > MAXV) begin ov = 1'b1; p = SAT ? MAXV : (p % 65536); end
            p = p + longint'(m_c[i]);
            if (p > MAXV) begin ov = 1'b1; p = SAT ? MAXV : (p % 65536); end
            s = p;
        end
        res = 32'(s);
    endfunction

    task automatic write_coef(input int unsigned a, input int unsigned v);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(a);
        bus.coef_data = 16'(v);
        step();
        bus.coef_we   = 1'b0;
        if (a <= D) m_c[a] = v & 32'hFFFF;
    endtask

    task automatic start_eval(input int unsigned x);
        bus.x_in  = 8'(x);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, capturing outputs at the done cycle, then returns to IDLE.
    task automatic wait_capture(output logic [15:0] res, output logic ov, output logic zr,
                                output int cycles, output bit busy_ok, output bit seen);
        cycles = 0; busy_ok = 1'b1; res = 'x; ov = 'x; zr = 'x;
        while (bus.done !== 1'b1 && cycles < 20) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            step();
            cycles++;
        end
        seen = (bus.done === 1'b1);
        if (seen) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            res = bus.result; ov = bus.overflow; zr = bus.zero;
            step();
        end
    endtask

    task automatic run_eval(input int unsigned x, output logic [15:0] res, output logic ov,
                            output logic zr, output int cycles, output bit busy_ok, output bit seen);
        start_eval(x);
        wait_capture(res, ov, zr, cycles, busy_ok, seen);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.coef_we = 0; bus.coef_addr = 0; bus.coef_data = 0; bus.x_in = 0; bus.start = 0;
        bus0.coef_we = 0; bus0.coef_addr = 0; bus0.coef_data = 0; bus0.x_in = 0; bus0.start = 0;
        for (int i = 0; i <= int'(D); i++) m_c[i] = 0;
        step(); step();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
        vectors++; if (bus.result !== 16'd0) begin miscompares++; $display("FAIL reset_result got %0d want 0", bus.result); end
        vectors++; if (bus.zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got %b want 1", bus.zero); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        vectors++; if (bus0.result !== 16'd0 || bus0.busy !== 1'b0) begin miscompares++; $display("FAIL reset_deg0 got result=%0d busy=%b want 0/0", bus0.result, bus0.busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] r; logic ov, zr; int cyc; bit bok, seen; int unsigned er; bit eo;
        write_coef(0, 5); write_coef(1, 3); write_coef(2, 2);
        model(4, er, eo);
        run_eval(4, r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || cyc != 2 * int'(D)) begin miscompares++; $display("FAIL basic_latency got seen=%0d cycles=%0d want 1/%0d", seen, cyc, 2 * D); end
        vectors++; if (!bok) begin miscompares++; $display("FAIL basic_busy got gap want busy high throughout"); end
        vectors++; if (r !== 16'(er) || er != 49) begin miscompares++; $display("FAIL basic_result got %0d want %0d", r, er); end
        vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL basic_overflow got %b want 0", ov); end
        vectors++; if (zr !== 1'b0) begin miscompares++; $display("FAIL basic_zero got %b want 0", zr); end
        vectors++; if (bus.result !== 16'd49 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL basic_hold got result=%0d busy=%b done=%b want 49/0/0", bus.result, bus.busy, bus.done); end
    endtask

    task automatic test_wrap();
        logic [15:0] r; logic ov, zr; int cyc; bit bok, seen; int unsigned er; bit eo;
        write_coef(2, 2); write_coef(1, 0); write_coef(0, 0);
        model(255, er, eo);
        run_eval(255, r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || r !== 16'(er) || r !== (SAT ? 16'd65535 : 16'd64514)) begin miscompares++; $display("FAIL wrap_result got %0d want %0d", r, er); end
        vectors++; if (ov !== 1'b1 || !eo) begin miscompares++; $display("FAIL wrap_overflow got %b want 1", ov); end
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL wrap_overflow_hold got %b want 1", bus.overflow); end
        model(1, er, eo);
        run_eval(1, r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || r !== 16'(er) || ov !== 1'b0) begin miscompares++; $display("FAIL wrap_clear got result=%0d ov=%b want %0d/0", r, ov, er); end
    endtask

    task automatic test_zero();
        logic [15:0] r; logic ov, zr; int cyc; bit bok, seen;
        write_coef(0, 0); write_coef(1, 0); write_coef(2, 0);
        run_eval(7, r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || r !== 16'd0) begin miscompares++; $display("FAIL zero_result got %0d want 0", r); end
        vectors++; if (zr !== 1'b1) begin miscompares++; $display("FAIL zero_flag got %b want 1", zr); end
        vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL zero_overflow got %b want 0", ov); end
    endtask

    task automatic test_busy_rules();
        logic [15:0] r, rdone; logic ov, zr; int cyc, npulse; bit bok, seen;
        write_coef(0, 5); write_coef(1, 3); write_coef(2, 2);
        start_eval(4);
        step();
        bus.start = 1'b1; bus.x_in = 8'd9;
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = 16'd100;
        step();
        bus.start = 1'b0; bus.coef_we = 1'b0;
        npulse = 0; rdone = 'x;
        for (int c = 0; c < 12; c++) begin
            if (bus.done === 1'b1) begin npulse++; rdone = bus.result; end
            step();
        end
        vectors++; if (npulse != 1) begin miscompares++; $display("FAIL busy_pulses got %0d want 1", npulse); end
        vectors++; if (rdone !== 16'd49) begin miscompares++; $display("FAIL busy_result got %0d want 49", rdone); end
        run_eval(4, r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || r !== 16'd49) begin miscompares++; $display("FAIL busy_rerun got %0d want 49", r); end
    endtask

    task automatic test_write_with_start();
        logic [15:0] r; logic ov, zr; int cyc; bit bok, seen; int unsigned e_old, e_new; bit eo;
        write_coef(0, 1); write_coef(1, 1); write_coef(2, 1);
        model(2, e_old, eo);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd2; bus.coef_data = 16'd3;
        bus.x_in = 8'd2; bus.start = 1'b1;
        step();
        bus.coef_we = 1'b0; bus.start = 1'b0;
        m_c[2] = 3;
        model(2, e_new, eo);
        wait_capture(r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || r !== 16'(e_old)) begin miscompares++; $display("FAIL wws_old got %0d want %0d", r, e_old); end
        run_eval(2, r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || r !== 16'(e_new)) begin miscompares++; $display("FAIL wws_new got %0d want %0d", r, e_new); end
    endtask

    task automatic test_random();
        logic [15:0] r; logic ov, zr; int cyc; bit bok, seen; int unsigned er, x; bit eo;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i <= int'(D); i++)
                write_coef(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : ($urandom & 32'hFFFF));
            if ($urandom_range(0, 3) == 0) write_coef(3, $urandom & 32'hFFFF);
            x = $urandom_range(0, 255);
            model(x, er, eo);
            run_eval(x, r, ov, zr, cyc, bok, seen);
            vectors++; if (!seen || cyc != 2 * int'(D) || r !== 16'(er)) begin miscompares++; $display("FAIL rand_result[%0d] got %0d (seen=%0d cyc=%0d) want %0d", n, r, seen, cyc, er); end
            vectors++; if (ov !== eo || zr !== (er == 0)) begin miscompares++; $display("FAIL rand_flags[%0d] got ov=%b zero=%b want %b/%b", n, ov, zr, eo, er == 0); end
        end
    endtask

    task automatic test_back_to_back();
        int t[$]; logic [15:0] rq[$]; int unsigned er, x; bit eo; int guard;
        for (int i = 0; i <= int'(D); i++) write_coef(i, $urandom_range(0, 255));
        x = $urandom_range(0, 255);
        model(x, er, eo);
        bus.x_in = 8'(x); bus.start = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            if (bus.done === 1'b1) begin t.push_back(c); rq.push_back(bus.result); end
            step();
        end
        bus.start = 1'b0;
        vectors++; if (t.size() != 3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", t.size()); end
        else begin
            vectors++; if (t[0] != 2 * int'(D) || t[1] - t[0] != 2 * int'(D) + 2 || t[2] - t[1] != 2 * int'(D) + 2) begin miscompares++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 4,10,16", t[0], t[1], t[2]); end
            for (int k = 0; k < 3; k++) begin
                vectors++; if (rq[k] !== 16'(er)) begin miscompares++; $display("FAIL b2b_result[%0d] got %0d want %0d", k, rq[k], er); end
            end
        end
        guard = 0;
        while (bus.busy === 1'b1 && guard < 20) begin step(); guard++; end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r; logic ov, zr; int cyc; bit bok, seen;
        write_coef(0, 5); write_coef(1, 3); write_coef(2, 2);
        start_eval(4);
        step();
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0/0", bus.busy, bus.done); end
        vectors++; if (bus.result !== 16'd0 || bus.zero !== 1'b1) begin miscompares++; $display("FAIL rstmid_result got %0d zero=%b want 0/1", bus.result, bus.zero); end
        step(); step();
        rst = 1'b0;
        for (int i = 0; i <= int'(D); i++) m_c[i] = 0;
        step();
        run_eval(9, r, ov, zr, cyc, bok, seen);
        vectors++; if (!seen || r !== 16'd0) begin miscompares++; $display("FAIL rstmid_coefs got %0d want 0", r); end
    endtask

    task automatic test_degree0();
        int unsigned v;
        for (int n = 0; n < 3; n++) begin
            v = (n == 0) ? 32'h1234 : ($urandom & 32'hFFFF);
            bus0.coef_we = 1'b1; bus0.coef_addr = 1'b0; bus0.coef_data = 16'(v);
            step();
            bus0.coef_addr = 1'b1; bus0.coef_data = 16'(~v);
            step();
            bus0.coef_we = 1'b0;
            bus0.x_in = 8'($urandom_range(0, 255)); bus0.start = 1'b1;
            step();
            bus0.start = 1'b0;
            vectors++; if (bus0.done !== 1'b1 || bus0.busy !== 1'b1) begin miscompares++; $display("FAIL deg0_latency[%0d] got done=%b busy=%b want 1/1", n, bus0.done, bus0.busy); end
            vectors++; if (bus0.result !== 16'(v) || bus0.overflow !== 1'b0) begin miscompares++; $display("FAIL deg0_result[%0d] got %0h ov=%b want %0h/0", n, bus0.result, bus0.overflow, v); end
            step();
            vectors++; if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin miscompares++; $display("FAIL deg0_idle[%0d] got done=%b busy=%b want 0/0", n, bus0.done, bus0.busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_busy_rules();
        test_write_with_start();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_degree0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
